// File: rtl/reg_loader.sv
// Serial-to-parallel register loader: shifts WIDTH bits in MSB first, then strobes a one-cycle load.
// Optional even-parity check enabled by defining REG_LOADER_PARITY_EN.
module reg_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             bit_vld,
  input  logic             ser_in,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             enable,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef REG_LOADER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_LOAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_last_bit;

  assign w_sr_nxt   = {r_sr[WIDTH-2:0], ser_in};
  assign w_last_bit = bit_vld && (r_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
`ifdef REG_LOADER_PARITY_EN
      S_SHIFT: if (w_last_bit) w_next = S_PARITY;
      // Even parity: data bits plus parity bit must hold an even number of ones.
      S_PARITY: if (bit_vld) w_next = (^{r_sr, ser_in}) ? S_IDLE : S_LOAD;
`else
      S_SHIFT: if (w_last_bit) w_next = S_LOAD;
`endif
      S_LOAD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef REG_LOADER_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= (r_state == S_PARITY) && bit_vld && (^{r_sr, ser_in});
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt  <= '0;
      r_sr   <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_sr  <= '0;
          end
        end
        S_SHIFT: begin
          if (bit_vld) begin
            r_sr  <= w_sr_nxt;
            r_cnt <= r_cnt + 1'b1;
`ifndef REG_LOADER_PARITY_EN
            if (r_cnt == LAST_IDX) r_data <= w_sr_nxt;
`endif
          end
        end
`ifdef REG_LOADER_PARITY_EN
        S_PARITY: begin
          if (bit_vld && !(^{r_sr, ser_in})) r_data <= r_sr;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign enable = (r_state == S_LOAD);
  assign data   = r_data;

endmodule

// File: tb/tb_reg_loader.sv
// Directed self-checking bench for reg_loader (WIDTH=8); parity steps compile in with REG_LOADER_PARITY_EN.
module tb_reg_loader;

  localparam int W = 8;
`ifdef REG_LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         start = 1'b0;
  logic         bit_vld = 1'b0;
  logic         ser_in = 1'b0;
  logic         busy;
  logic [W-1:0] data;
  logic         enable;
  logic         parity_err;

  int tests = 0;
  int fails = 0;
  int en_seen = 0;
  int ticks = 0;

  reg_loader #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .start      (start),
    .bit_vld    (bit_vld),
    .ser_in     (ser_in),
    .busy       (busy),
    .data       (data),
    .enable     (enable),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
    if (enable) en_seen++;
  endtask

  task automatic shift_bit(input logic b);
    bit_vld = 1'b1;
    ser_in  = b;
    tick();
    bit_vld = 1'b0;
    ser_in  = 1'b0;
  endtask

  task automatic stall();
    bit_vld = 1'b0;
    ser_in  = 1'b1;
    tick();
    ser_in  = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks = 0;
  endtask

  task automatic send_parity(input logic [W-1:0] w);
`ifdef REG_LOADER_PARITY_EN
    shift_bit(^w);
`else
    if (w === 'x) $display("[TB] unreachable");
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) shift_bit(w[i]);
    send_parity(w);
  endtask

  initial begin
    logic [W-1:0] w;

    // Reset state, asserted before any clock edge.
    #2;
    check("rst_busy", busy, 0);
    check("rst_enable", enable, 0);
    check("rst_data", data, 0);
    check("rst_perr", parity_err, 0);
    @(posedge clk); #1;
    rst_ = 1'b1;
    ser_in = 1'b1;
    bit_vld = 1'b1;
    tick();
    bit_vld = 1'b0;
    check("idle_ignores_bits", busy, 0);

    // 0xA5, no stalls.
    w = 8'hA5;
    en_seen = 0;
    begin_frame();
    check("a5_busy_after_start", busy, 1);
    for (int i = W - 1; i >= 1; i--) shift_bit(w[i]);
    check("a5_no_enable_early", enable, 0);
    shift_bit(w[0]);
    send_parity(w);
    check("a5_enable", enable, 1);
    check("a5_data", data, 8'hA5);
    check("a5_latency", ticks, W + PB);
    tick();
    check("a5_enable_drop", enable, 0);
    check("a5_busy_drop", busy, 0);
    check("a5_data_hold", data, 8'hA5);
    check("a5_pulse_count", en_seen, 1);

    // 0x3C with three stall cycles interleaved.
    w = 8'h3C;
    en_seen = 0;
    begin_frame();
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 6 || i == 4 || i == 2) stall();
      shift_bit(w[i]);
      if (i == 4) check("3c_data_held_midframe", data, 8'hA5);
    end
    send_parity(w);
    check("3c_enable", enable, 1);
    check("3c_data", data, 8'h3C);
    check("3c_latency", ticks, W + PB + 3);
    tick();
    check("3c_pulse_count", en_seen, 1);

    // 0x5A with start re-pulsed mid-frame and during LOAD.
    w = 8'h5A;
    en_seen = 0;
    begin_frame();
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 4) start = 1'b1;
      shift_bit(w[i]);
      start = 1'b0;
    end
    send_parity(w);
    check("5a_enable", enable, 1);
    check("5a_data", data, 8'h5A);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("5a_start_in_load_ignored", busy, 0);
    tick();
    tick();
    check("5a_still_idle", busy, 0);
    check("5a_pulse_count", en_seen, 1);

    // Abort after four bits of 0xFF.
    en_seen = 0;
    begin_frame();
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    check("abort_busy_before", busy, 1);
    rst_ = 1'b0;
    #1;
    check("abort_busy_async", busy, 0);
    check("abort_data", data, 0);
    check("abort_enable", enable, 0);
    tick();
    check("abort_busy_held", busy, 0);

    // Release reset; start must be taken on the very first edge. Then 0x01 and 0xFE back to back.
    rst_ = 1'b1;
    begin_frame();
    check("post_reset_start", busy, 1);
    send_word(8'h01);
    check("b2b_first_enable", enable, 1);
    check("b2b_first_data", data, 8'h01);
    tick();
    check("b2b_idle_gap", busy, 0);
    begin_frame();
    check("b2b_second_start", busy, 1);
    send_word(8'hFE);
    check("b2b_second_enable", enable, 1);
    tick();
    check("b2b_final_data", data, 8'hFE);
    check("b2b_pulse_count", en_seen, 2);
    check("abort_no_enable_total", en_seen, 2);

`ifdef REG_LOADER_PARITY_EN
    // Good parity, then a different good word, then a bad-parity frame.
    en_seen = 0;
    begin_frame();
    for (int i = W - 1; i >= 0; i--) shift_bit(w[i] ^ w[i] ^ (i == 7 || i == 0));
    shift_bit(1'b0);
    check("par_good_enable", enable, 1);
    check("par_good_data", data, 8'h81);
    tick();
    begin_frame();
    send_word(8'h3C);
    tick();
    check("par_second_data", data, 8'h3C);
    begin_frame();
    w = 8'h81;
    for (int i = W - 1; i >= 0; i--) shift_bit(w[i]);
    shift_bit(1'b1);
    check("par_bad_err", parity_err, 1);
    check("par_bad_enable", enable, 0);
    check("par_bad_busy", busy, 0);
    check("par_bad_data_kept", data, 8'h3C);
    tick();
    check("par_err_one_cycle", parity_err, 0);
    check("par_pulse_count", en_seen, 2);
`else
    check("perr_tied_low", parity_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
